// File: rtl/instr_sequencer.sv
// Program sequencer: a small writable {opcode, operand} memory stepped by a program
// counter, issuing one opcode per instruction slot in free-run or single-step mode.
module instr_sequencer #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW+2:0] prog_wdata,
  input  logic          start,
  input  logic          step_mode,
  input  logic          step,
  output logic [2:0]    Opcode,
  output logic [DW-1:0] operand,
  output logic          issue,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_STEP,
    S_HALTED
  } state_t;

  localparam logic [2:0]    OP_HALT = 3'b111;
  localparam logic [AW-1:0] PC_LAST = '1;

  state_t        state;
  logic [DW+2:0] mem [2**AW];
  logic [2:0]    ir_op;
  logic [DW+2:0] fetch_word;
  logic [2:0]    fetch_op;
  logic          prog_ok;

  // Only the real control-unit opcodes are issued; NOP, reserved and HALT are silent.
  function automatic logic is_issued(input logic [2:0] op);
    return (op >= 3'b001) && (op <= 3'b101);
  endfunction

  assign fetch_word = mem[pc];
  assign fetch_op   = fetch_word[DW+2:DW];
  assign prog_ok    = prog_we && ((state == S_IDLE) || (state == S_HALTED));

  // NOTE: program memory has no reset so it maps onto plain RAM and survives a reset.
  always_ff @(posedge clk) begin
    if (prog_ok) mem[prog_addr] <= prog_wdata;
  end

  // Outputs are loaded on the FETCH->ISSUE edge from the word being fetched, so they
  // are valid exactly for the ISSUE cycle; only the opcode is kept for ISSUE decisions.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir_op   <= '0;
      Opcode  <= '0;
      operand <= '0;
      issue   <= 1'b0;
    end else begin
      // NOTE: outputs default to zero every cycle; only the FETCH branch raises them.
      Opcode  <= '0;
      operand <= '0;
      issue   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          ir_op <= fetch_op;
          if (is_issued(fetch_op)) begin
            Opcode  <= fetch_op;
            operand <= fetch_word[DW-1:0];
            issue   <= 1'b1;
          end
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (ir_op == OP_HALT) begin
            state <= S_HALTED;
          end else if (pc == PC_LAST) begin
            state <= S_HALTED;
          end else begin
            pc    <= pc + 1'b1;
            state <= step_mode ? S_WAIT_STEP : S_FETCH;
          end
        end
        S_WAIT_STEP: begin
          if (step || !step_mode) state <= S_FETCH;
        end
        S_HALTED: begin
          if (start) begin
            pc    <= '0;
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (state == S_FETCH) || (state == S_ISSUE) || (state == S_WAIT_STEP);
  assign halted = (state == S_HALTED);

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a program-level model predicts the issue stream,
// a negedge monitor pops and compares every issued instruction.
module tb_instr_sequencer;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [DW+2:0] prog_wdata = '0;
  logic          start = 1'b0;
  logic          step_mode = 1'b0;
  logic          step = 1'b0;
  logic [2:0]    Opcode;
  logic [DW-1:0] operand;
  logic          issue;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;

  instr_sequencer #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .start(start), .step_mode(step_mode), .step(step),
    .Opcode(Opcode), .operand(operand), .issue(issue), .pc(pc),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] opnd;
  } exp_t;

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          start_cyc = 0;
  bit          mon_en = 1'b0;
  exp_t        exp_q[$];
  int          issue_times[$];
  logic [DW+2:0] model_mem [DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle either an issued instruction that must match the queue head,
  // or all-zero outputs.
  always @(negedge clk) begin
    if (mon_en) begin
      check("busy_halted_exclusive", {31'd0, busy & halted}, 32'd0);
      if (issue === 1'b1) begin
        issue_times.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_issue: got op %0h operand %0h expected no issue", Opcode, operand);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("issue_opcode", {29'd0, Opcode}, {29'd0, e.op});
          check("issue_operand", {24'd0, operand}, {24'd0, e.opnd});
        end
      end else begin
        check("quiet_opcode", {29'd0, Opcode}, 32'd0);
        check("quiet_operand", {24'd0, operand}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [2:0] op, input logic [DW-1:0] v, input bit accepted);
    prog_we    = 1'b1;
    prog_addr  = a[AW-1:0];
    prog_wdata = {op, v};
    tick();
    prog_we = 1'b0;
    if (accepted) model_mem[a] = {op, v};
  endtask

  // Program-level model: walk memory from 0, stop on HALT or at the last word.
  task automatic model_run(output int fin_pc);
    logic [2:0] op;
    fin_pc = DEPTH - 1;
    for (int p = 0; p < DEPTH; p++) begin
      op = model_mem[p][DW+2:DW];
      if (op == 3'b111) begin
        fin_pc = p;
        return;
      end
      if (op >= 3'b001 && op <= 3'b101)
        exp_q.push_back(exp_t'{op: op, opnd: model_mem[p][DW-1:0]});
    end
  endtask

  task automatic do_start(input string name);
    start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
    check({name, "_start_pc"}, {28'd0, pc}, 32'd0);
    check({name, "_start_busy"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_halt(input string name, input int exp_pc);
    int k = 0;
    while (halted !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    check({name, "_halted"}, {31'd0, halted}, 32'd1);
    check({name, "_final_pc"}, {28'd0, pc}, exp_pc);
    check({name, "_not_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_drained"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_issues(input int n);
    int k = 0;
    while (issue_times.size() < n && k < 50) begin
      tick();
      k++;
    end
  endtask

  task automatic run_free(input string name);
    int fp;
    step_mode = 1'b0;
    issue_times.delete();
    model_run(fp);
    do_start(name);
    wait_halt(name, fp);
  endtask

  task automatic settle_check(input string name, input int n);
    repeat (3) tick();
    check({name, "_count"}, issue_times.size(), n);
    check({name, "_parked_busy"}, {31'd0, busy}, 32'd1);
  endtask

  initial begin
    int fp;
    logic [DW-1:0] rv;

    // Reset state
    tick();
    tick();
    check("rst_opcode", {29'd0, Opcode}, 32'd0);
    check("rst_operand", {24'd0, operand}, 32'd0);
    check("rst_issue", {31'd0, issue}, 32'd0);
    check("rst_pc", {28'd0, pc}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Reset landing in the ISSUE cycle aborts cleanly
    load(0, 3'b001, 8'h05, 1'b1);
    exp_q.push_back(exp_t'{op: 3'b001, opnd: 8'h05});
    do_start("abort");
    tick();
    check("abort_pre_issue", {31'd0, issue}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_opcode", {29'd0, Opcode}, 32'd0);
    check("abort_issue", {31'd0, issue}, 32'd0);
    check("abort_pc", {28'd0, pc}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_halted", {31'd0, halted}, 32'd0);
    check("abort_drained", exp_q.size(), 32'd0);
    exp_q.delete();

    // Basic program, free-run
    load(1, 3'b010, 8'h03, 1'b1);
    load(2, 3'b100, 8'h00, 1'b1);
    load(3, 3'b101, 8'h00, 1'b1);
    load(4, 3'b111, 8'h00, 1'b1);
    run_free("free");
    check("free_issue_count", issue_times.size(), 32'd4);
    if (issue_times.size() == 4) begin
      // FETCH occupies cycle start_cyc, ISSUE the one after
      check("free_first_latency", issue_times[0] - start_cyc, 32'd1);
      for (int i = 1; i < 4; i++)
        check("free_issue_gap", issue_times[i] - issue_times[i-1], 32'd2);
    end

    // Same program, single-step
    step_mode = 1'b1;
    issue_times.delete();
    model_run(fp);
    do_start("step");
    wait_issues(1);
    settle_check("step_first", 1);
    for (int n = 2; n <= 3; n++) begin
      step = 1'b1;
      repeat (3) tick();
      step = 1'b0;
      wait_issues(n);
      settle_check("step_pulse", n);
    end
    step_mode = 1'b0;
    wait_halt("step_resume", fp);
    check("step_total", issue_times.size(), 32'd4);

    // NOP and reserved slots consume time but never issue
    load(0, 3'b001, 8'h11, 1'b1);
    load(1, 3'b000, 8'hAA, 1'b1);
    load(2, 3'b110, 8'hBB, 1'b1);
    load(3, 3'b011, 8'h22, 1'b1);
    load(4, 3'b111, 8'h00, 1'b1);
    run_free("nop");
    check("nop_issue_count", issue_times.size(), 32'd2);
    if (issue_times.size() == 2)
      check("nop_gap", issue_times[1] - issue_times[0], 32'd6);

    // Randomized programs
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < DEPTH; a++) begin
        rv = 8'($urandom);
        load(a, 3'($urandom_range(0, 7)), rv, 1'b1);
      end
      run_free("rand");
    end

    // Full memory of ADDs: halts at the last word without wrapping, then restarts
    for (int a = 0; a < DEPTH; a++) begin
      rv = 8'($urandom);
      load(a, 3'b011, rv, 1'b1);
    end
    run_free("full");
    check("full_issue_count", issue_times.size(), 32'd16);
    run_free("full_restart");
    check("full_restart_count", issue_times.size(), 32'd16);

    // Writes while busy are dropped; writes while halted land
    load(0, 3'b001, 8'h11, 1'b1);
    load(1, 3'b111, 8'h00, 1'b1);
    step_mode = 1'b1;
    issue_times.delete();
    model_run(fp);
    do_start("busywr");
    wait_issues(1);
    tick();
    load(0, 3'b010, 8'h77, 1'b0);
    check("busywr_parked", {31'd0, busy}, 32'd1);
    step_mode = 1'b0;
    wait_halt("busywr", fp);
    run_free("busywr_check");
    load(0, 3'b010, 8'h77, 1'b1);
    run_free("haltwr_check");
    check("haltwr_count", issue_times.size(), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
